dmem_arbiter: RTL and testbench

Two-master, one-slave arbiter for the single-port data memory of the multicycle CPU. Master 0 is the CPU data port and master 1 is a secondary bus master such as the SPI boot loader or a DMA engine. The arbiter sequences every access through a three-state FSM against a memory with one cycle of read latency. It returns read data with a one-cycle acknowledge, and bounds how long master 1 can be starved.

---
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two master ports and the memory port of the
// data-memory arbiter.
//   m0_* / m1_* : request side (req, addr, we, wdata) and response side
//                 (ack, rdata) for the CPU data port and the secondary master
//   err         : out-of-range flag, pulses with ack
//   mem_*       : single-port memory with registered read data
// Modports: slave = arbiter view, master = masters/memory (testbench) view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [3:0]        m0_we;
  logic [31:0]       m0_wdata;
  logic              m0_ack;
  logic [31:0]       m0_rdata;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic [3:0]        m1_we;
  logic [31:0]       m1_wdata;
  logic              m1_ack;
  logic [31:0]       m1_rdata;

  logic              err;

  logic              mem_ce;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_we, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_addr, m1_we, m1_wdata,
    output m1_ack, m1_rdata,
    output err,
    output mem_ce, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_we, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_addr, m1_we, m1_wdata,
    input  m1_ack, m1_rdata,
    input  err,
    input  mem_ce, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter in front of a single-port data memory with
// one cycle of read latency. Every access runs IDLE/RESP -> ACCESS -> RESP.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dmem_arbiter_if.slave (master 0/1 ports, err, memory port)
// PRIO_M0=1 gives master 0 priority, with master 1 forced in after MAX_WAIT
// master-0 grants; PRIO_M0=0 alternates on contention.
module dmem_arbiter #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] MEM_BYTES = 32'h0002_0000,
  parameter int          PRIO_M0   = 1,
  parameter int          MAX_WAIT  = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_W-1:0] MEM_LIM = ADDR_W'(MEM_BYTES);
  localparam logic [3:0]        MAX_W4  = 4'(MAX_WAIT);

  state_t state, state_nxt;
  logic        owner, last_grant;
  logic [3:0]  wait_cnt;
  logic        flag;   // current access is out of range
  logic        rd;     // current access is a read

  logic [1:0]              req, req_eff;
  logic [1:0][ADDR_W-1:0]  addr;
  logic [1:0][3:0]         we;
  logic [1:0][31:0]        wdata;
  logic                    win_vld, win, win_in_range;

  logic              mem_ce_q;
  logic [3:0]        mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       rdata_v;

  assign req   = {bus.m1_req,   bus.m0_req};
  assign addr  = {bus.m1_addr,  bus.m0_addr};
  assign we    = {bus.m1_we,    bus.m0_we};
  assign wdata = {bus.m1_wdata, bus.m0_wdata};

  always_comb begin
    state_nxt = state;
    win_vld   = 1'b0;
    win       = 1'b0;
    req_eff   = req;
    // The owner being acked cannot win the overlapping arbitration, so a
    // waiting master always gets the next slot.
    if (state == RESP) req_eff[owner] = 1'b0;
    case (state)
      IDLE, RESP: begin
        win_vld = |req_eff;
        if (req_eff == 2'b11)
          win = (PRIO_M0 != 0) ? (wait_cnt >= MAX_W4) : ~last_grant;
        else
          win = req_eff[1];
        state_nxt = win_vld ? ACCESS : IDLE;
      end
      ACCESS:  state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  assign win_in_range = addr[win] < MEM_LIM;

  // Memory strobes are registered on the grant edge so they are valid for
  // exactly the ACCESS cycle; address/data hold between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      wait_cnt    <= 4'd0;
      flag        <= 1'b0;
      rd          <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 4'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      state    <= state_nxt;
      mem_ce_q <= 1'b0;
      mem_we_q <= 4'd0;
      if (win_vld) begin
        owner      <= win;
        last_grant <= win;
        flag       <= ~win_in_range;
        rd         <= (we[win] == 4'd0);
        if (win)
          wait_cnt <= 4'd0;
        else if (req[1] && wait_cnt != 4'd15)
          wait_cnt <= wait_cnt + 4'd1;
        if (win_in_range) begin
          mem_ce_q    <= 1'b1;
          mem_we_q    <= we[win];
          mem_addr_q  <= addr[win];
          mem_wdata_q <= wdata[win];
        end
      end
    end
  end

  assign bus.mem_ce    = mem_ce_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign rdata_v      = (rd && !flag) ? bus.mem_rdata : 32'd0;
  assign bus.m0_ack   = (state == RESP) && !owner;
  assign bus.m1_ack   = (state == RESP) &&  owner;
  assign bus.err      = (state == RESP) &&  flag;
  assign bus.m0_rdata = bus.m0_ack ? rdata_v : 32'd0;
  assign bus.m1_rdata = bus.m1_ack ? rdata_v : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32)) bp ();
  dmem_arbiter_if #(.ADDR_W(32)) br ();

  dmem_arbiter #(.ADDR_W(32), .MEM_BYTES(32'h0002_0000), .PRIO_M0(1), .MAX_WAIT(1))
    u_pri (.clk(clk), .rst(rst), .bus(bp));
  dmem_arbiter #(.ADDR_W(32), .MEM_BYTES(32'h0002_0000), .PRIO_M0(0), .MAX_WAIT(4))
    u_rr  (.clk(clk), .rst(rst), .bus(br));

  // behavioural memories, one cycle read latency, byte write enables
  logic [31:0] mem_p [0:1023];
  logic [31:0] mem_r [0:1023];
  logic        pre_en;
  logic [9:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) begin
    if (pre_en) mem_p[pre_idx] <= pre_val;
    else if (bp.mem_ce) begin
      for (int b = 0; b < 4; b++)
        if (bp.mem_we[b]) mem_p[bp.mem_addr[11:2]][8*b +: 8] <= bp.mem_wdata[8*b +: 8];
      bp.mem_rdata <= mem_p[bp.mem_addr[11:2]];
    end
  end

  always @(posedge clk) begin
    if (pre_en) mem_r[pre_idx] <= pre_val;
    else if (br.mem_ce) begin
      for (int b = 0; b < 4; b++)
        if (br.mem_we[b]) mem_r[br.mem_addr[11:2]][8*b +: 8] <= br.mem_wdata[8*b +: 8];
      br.mem_rdata <= mem_r[br.mem_addr[11:2]];
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] v);
    pre_idx = idx; pre_val = v; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  int seq[$];
  int c, m0cnt;
  bit seen;

  initial begin
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    bp.m0_req = 0; bp.m0_addr = 0; bp.m0_we = 0; bp.m0_wdata = 0;
    bp.m1_req = 0; bp.m1_addr = 0; bp.m1_we = 0; bp.m1_wdata = 0;
    br.m0_req = 0; br.m0_addr = 0; br.m0_we = 0; br.m0_wdata = 0;
    br.m1_req = 0; br.m1_addr = 0; br.m1_we = 0; br.m1_wdata = 0;
    rst = 1'b1;
    tick(); tick();

    // reset state
    chk("rst_m0_ack",   bp.m0_ack,    0);
    chk("rst_m1_ack",   bp.m1_ack,    0);
    chk("rst_err",      bp.err,       0);
    chk("rst_mem_ce",   bp.mem_ce,    0);
    chk("rst_mem_we",   bp.mem_we,    0);
    chk("rst_mem_addr", bp.mem_addr,  0);
    chk("rst_mem_wd",   bp.mem_wdata, 0);
    chk("rst_m0_rdata", bp.m0_rdata,  0);
    chk("rst_rr_ce",    br.mem_ce,    0);

    preload(10'h040, 32'hCAFE_BABE);   // 0x100
    preload(10'h041, 32'h1234_5678);   // 0x104
    preload(10'h000, 32'h1111_1111);   // alias of 0x2_0000 in the bench memory
    preload(10'h080, 32'h1122_3344);   // 0x200
    preload(10'h081, 32'h99AA_BBCC);   // 0x204
    rst = 1'b0;
    tick();

    // single read
    bp.m0_req = 1; bp.m0_addr = 32'h100; bp.m0_we = 0;
    tick();
    chk("rd_ce",     bp.mem_ce,   1);
    chk("rd_addr",   bp.mem_addr, 32'h100);
    chk("rd_we",     bp.mem_we,   0);
    chk("rd_ack_early", bp.m0_ack, 0);
    tick();
    chk("rd_ack",    bp.m0_ack,   1);
    chk("rd_data",   bp.m0_rdata, 32'hCAFE_BABE);
    chk("rd_err",    bp.err,      0);
    chk("rd_m1_ack", bp.m1_ack,   0);
    bp.m0_req = 0;
    tick();
    chk("rd_idle_ack", bp.m0_ack, 0);
    chk("rd_idle_ce",  bp.mem_ce, 0);

    // out-of-range write from master 1
    bp.m1_req = 1; bp.m1_addr = 32'h0002_0000; bp.m1_we = 4'hF; bp.m1_wdata = 32'hDEAD_BEEF;
    tick();
    chk("oor_ce1",   bp.mem_ce, 0);
    chk("oor_ack1",  bp.m1_ack, 0);
    tick();
    chk("oor_ce2",   bp.mem_ce,   0);
    chk("oor_ack",   bp.m1_ack,   1);
    chk("oor_err",   bp.err,      1);
    chk("oor_rdata", bp.m1_rdata, 0);
    chk("oor_m0ack", bp.m0_ack,   0);
    bp.m1_req = 0;
    tick();
    chk("oor_mem",   mem_p[0],    32'h1111_1111);
    chk("oor_err_clr", bp.err,    0);

    // both masters requesting continuously: strict alternation from master 0
    bp.m0_addr = 32'h100; bp.m0_we = 0;
    bp.m1_addr = 32'h104; bp.m1_we = 0;
    bp.m0_req = 1; bp.m1_req = 1;
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("alt_one_ack", {31'd0, bp.m0_ack & bp.m1_ack}, 0);
      if (bp.m0_ack) begin
        chk("alt_d0", bp.m0_rdata, 32'hCAFE_BABE);
        seq.push_back(0);
      end
      if (bp.m1_ack) begin
        chk("alt_d1", bp.m1_rdata, 32'h1234_5678);
        seq.push_back(1);
        if (seq.size() >= 20) begin
          bp.m0_req = 0; bp.m1_req = 0;
          break;
        end
      end
    end
    chk("alt_n", seq.size(), 20);
    foreach (seq[i]) chk($sformatf("alt_ord%0d", i), seq[i], i % 2);
    tick();
    tick();

    // master 0 keeps requesting while master 1 waits
    bp.m0_req = 1;
    tick();
    bp.m1_req = 1;
    c = 0; m0cnt = 0; seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      c++;
      if (bp.m0_ack) m0cnt++;
      if (bp.m1_ack) begin
        seen = 1;
        chk("stv_d1", bp.m1_rdata, 32'h1234_5678);
        bp.m1_req = 0;
        break;
      end
    end
    chk("stv_seen", {31'd0, seen}, 1);
    chk("stv_lat",  {31'd0, c <= 4}, 1);
    chk("stv_m0n",  {31'd0, m0cnt <= 1}, 1);
    tick();
    chk("stv_m0_ce", bp.mem_ce, 1);
    tick();
    chk("stv_m0_ack", bp.m0_ack, 1);
    bp.m0_req = 0;
    tick();
    tick();

    // reset during ACCESS aborts the read; the re-request completes
    bp.m0_req = 1; bp.m0_addr = 32'h100; bp.m0_we = 0;
    tick();
    chk("rsa_ce", bp.mem_ce, 1);
    rst = 1'b1;
    tick();
    chk("rsa_ack",  bp.m0_ack,   0);
    chk("rsa_ce0",  bp.mem_ce,   0);
    chk("rsa_addr", bp.mem_addr, 0);
    chk("rsa_err",  bp.err,      0);
    rst = 1'b0;
    tick();
    chk("rsa_ack2", bp.m0_ack, 0);
    chk("rsa_ce2",  bp.mem_ce, 1);
    tick();
    chk("rsa_ack3", bp.m0_ack,   1);
    chk("rsa_data", bp.m0_rdata, 32'hCAFE_BABE);
    bp.m0_req = 0;
    tick();

    // round-robin: simultaneous first requests, byte-enable writes
    br.m0_req = 1; br.m0_addr = 32'h200; br.m0_we = 4'b0011; br.m0_wdata = 32'hAAAA_5555;
    br.m1_req = 1; br.m1_addr = 32'h204; br.m1_we = 4'b1100; br.m1_wdata = 32'h7777_8888;
    tick();
    chk("rr_ce0",   br.mem_ce,   1);
    chk("rr_we0",   br.mem_we,   4'b0011);
    chk("rr_addr0", br.mem_addr, 32'h200);
    tick();
    chk("rr_ack0",  br.m0_ack,   1);
    chk("rr_nack1", br.m1_ack,   0);
    br.m0_req = 0;
    tick();
    chk("rr_we1",   br.mem_we,   4'b1100);
    chk("rr_addr1", br.mem_addr, 32'h204);
    tick();
    chk("rr_ack1",  br.m1_ack,   1);
    chk("rr_nack0", br.m0_ack,   0);
    br.m1_req = 0;
    tick();
    chk("rr_mem0", mem_r[10'h080], 32'h1122_5555);
    chk("rr_mem1", mem_r[10'h081], 32'h7777_BBCC);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
